// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce and a two-digit key history
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] num0,
    output logic [3:0] num1,
    output logic       new_key
);
    localparam int CW = $clog2((SCAN_CYCLES > DEBOUNCE_CYCLES ? SCAN_CYCLES : DEBOUNCE_CYCLES) + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [63:0]   KEYS      = 64'hDF0E_C987_B654_A321;
    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0] r, r_n, c, c_n, c_low;
    logic [3:0] col_m, col_s, num0_n, num1_n;
    logic new_key_n, c_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SCAN;
            cnt     <= '0;
            r       <= 2'd0;
            c       <= 2'd0;
            col_m   <= 4'hF;
            col_s   <= 4'hF;
            row     <= 4'b1110;
            num0    <= 4'h0;
            num1    <= 4'h0;
            new_key <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            r       <= r_n;
            c       <= c_n;
            col_m   <= col;
            col_s   <= col_m;
            row     <= ~(4'b0001 << r_n);
            num0    <= num0_n;
            num1    <= num1_n;
            new_key <= new_key_n;
        end
    end

    // cnt is shared by every state and restarts on each transition
    always_comb begin
        c_low     = ~col_s[0] ? 2'd0 : ~col_s[1] ? 2'd1 : ~col_s[2] ? 2'd2 : 2'd3;
        c_hi      = col_s[c];
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        r_n       = r;
        c_n       = c;
        num0_n    = num0;
        num1_n    = num1;
        new_key_n = 1'b0;
        case (state)
            SCAN: if (cnt == SCAN_LAST) begin
                cnt_n = '0;
                if (col_s == 4'hF) r_n = r + 2'd1;
                else begin
                    c_n     = c_low;
                    state_n = PRESS_DB;
                end
            end
            PRESS_DB: if (c_hi) begin
                state_n = SCAN;
                cnt_n   = '0;
            end else if (cnt == DB_LAST) begin
                num1_n    = num0;
                num0_n    = KEYS[{r, c, 2'b00} +: 4];
                new_key_n = 1'b1;
                state_n   = HELD;
                cnt_n     = '0;
            end
            HELD: if (c_hi) begin
                state_n = REL_DB;
                cnt_n   = '0;
            end
            REL_DB: if (!c_hi) begin
                state_n = HELD;
                cnt_n   = '0;
            end else if (cnt == DB_LAST) begin
                state_n = SCAN;
                r_n     = r + 2'd1;
                cnt_n   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, history and reset with a modelled key matrix
module tb_keypad_scanner;
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] col, row, num0, num1;
    logic new_key;
    logic [15:0] pressed = '0;
    int passed = 0, total = 0, strobes = 0;

    keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .col(col), .row(row),
        .num0(num0), .num1(num1), .new_key(new_key)
    );

    always #5 clk = ~clk;

    // pressed index is r*4+c; a key pulls its column low only while its row is driven
    always_comb begin
        col = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (pressed[rr*4+cc] && row[rr] === 1'b0) col[cc] = 1'b0;
    end

    always @(posedge clk) if (new_key === 1'b1) strobes <= strobes + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (new_key === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        pressed = '0;
        repeat (2) @(negedge clk);
        total++; if (row !== 4'b1110) $display("FAIL reset_row: got %b want 1110", row); else passed++;
        total++; if (num0 !== 4'h0) $display("FAIL reset_num0: got %h want 0", num0); else passed++;
        total++; if (num1 !== 4'h0) $display("FAIL reset_num1: got %h want 0", num1); else passed++;
        total++; if (new_key !== 1'b0) $display("FAIL reset_new_key: got %b want 0", new_key); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_idle_scan;
        logic [3:0] exp;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            exp = ~(4'b0001 << ((n / 4) % 4));
            total++; if (row !== exp) $display("FAIL idle_row n=%0d: got %b want %b", n, row, exp); else passed++;
            total++; if (new_key !== 1'b0) $display("FAIL idle_new_key n=%0d: got %b want 0", n, new_key); else passed++;
        end
    endtask

    task automatic test_single_press;
        int s0;
        do_reset();
        s0 = strobes;
        pressed[5] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 15 || n == 17) begin
                total++; if (new_key !== 1'b0) $display("FAIL press_quiet n=%0d: got %b want 0", n, new_key); else passed++;
            end
            if (n == 16) begin
                total++; if (new_key !== 1'b1) $display("FAIL press_strobe: got %b want 1", new_key); else passed++;
                total++; if (num0 !== 4'h5) $display("FAIL press_num0: got %h want 5", num0); else passed++;
                total++; if (num1 !== 4'h0) $display("FAIL press_num1: got %h want 0", num1); else passed++;
            end
        end
        total++; if (row !== 4'b1101) $display("FAIL press_row_held: got %b want 1101", row); else passed++;
        pressed[5] = 1'b0;
        for (int m = 1; m <= 11; m++) begin
            @(negedge clk);
            if (m == 10) begin
                total++; if (row !== 4'b1101) $display("FAIL release_row_hold: got %b want 1101", row); else passed++;
            end
            if (m == 11) begin
                total++; if (row !== 4'b1011) $display("FAIL release_row_next: got %b want 1011", row); else passed++;
            end
        end
        repeat (2) @(negedge clk);
        total++; if (strobes - s0 !== 1) $display("FAIL press_count: got %0d want 1", strobes - s0); else passed++;
    endtask

    task automatic test_press_bounce;
        int s0;
        do_reset();
        s0 = strobes;
        pressed[5] = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            total++; if (new_key !== 1'b0) $display("FAIL bounce_new_key n=%0d: got %b want 0", n, new_key); else passed++;
            if (n == 13 || n == 16) begin
                total++; if (row !== 4'b1101) $display("FAIL bounce_row n=%0d: got %b want 1101", n, row); else passed++;
            end
            if (n == 17) begin
                total++; if (row !== 4'b1011) $display("FAIL bounce_row_next: got %b want 1011", row); else passed++;
            end
            if (n == 10) pressed[5] = 1'b0;
        end
        total++; if (num0 !== 4'h0) $display("FAIL bounce_num0: got %h want 0", num0); else passed++;
        total++; if (strobes - s0 !== 0) $display("FAIL bounce_count: got %0d want 0", strobes - s0); else passed++;
    endtask

    task automatic test_history;
        bit ok;
        do_reset();
        pressed[2] = 1'b1;
        wait_strobe(ok);
        total++; if (!ok) $display("FAIL hist_first_timeout: got no strobe want strobe"); else passed++;
        total++; if (num0 !== 4'h3) $display("FAIL hist_first_num0: got %h want 3", num0); else passed++;
        total++; if (num1 !== 4'h0) $display("FAIL hist_first_num1: got %h want 0", num1); else passed++;
        repeat (3) @(negedge clk);
        pressed[2] = 1'b0;
        pressed[11] = 1'b1;
        wait_strobe(ok);
        total++; if (!ok) $display("FAIL hist_second_timeout: got no strobe want strobe"); else passed++;
        total++; if (num0 !== 4'hC) $display("FAIL hist_second_num0: got %h want c", num0); else passed++;
        total++; if (num1 !== 4'h3) $display("FAIL hist_second_num1: got %h want 3", num1); else passed++;
        repeat (3) @(negedge clk);
        pressed = '0;
    endtask

    task automatic test_overlap;
        bit ok;
        int s0;
        logic [7:0] pat = 8'b1100_1100;
        do_reset();
        s0 = strobes;
        pressed[5] = 1'b1;
        wait_strobe(ok);
        total++; if (!ok || num0 !== 4'h5) $display("FAIL overlap_first: got ok=%0b num0=%h want ok=1 num0=5", ok, num0); else passed++;
        pressed[13] = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            pressed[5] = pat[i] ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        pressed[5] = 1'b0;
        wait_strobe(ok);
        total++; if (!ok) $display("FAIL overlap_second_timeout: got no strobe want strobe"); else passed++;
        total++; if (num0 !== 4'h0) $display("FAIL overlap_num0: got %h want 0", num0); else passed++;
        total++; if (num1 !== 4'h5) $display("FAIL overlap_num1: got %h want 5", num1); else passed++;
        total++; if (row !== 4'b0111) $display("FAIL overlap_row: got %b want 0111", row); else passed++;
        repeat (30) @(negedge clk);
        total++; if (strobes - s0 !== 2) $display("FAIL overlap_count: got %0d want 2", strobes - s0); else passed++;
        pressed = '0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int s0;
        do_reset();
        s0 = strobes;
        pressed[10] = 1'b1;
        wait_strobe(ok);
        total++; if (!ok || num0 !== 4'h9) $display("FAIL mid_press: got ok=%0b num0=%h want ok=1 num0=9", ok, num0); else passed++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (row !== 4'b1110) $display("FAIL mid_row: got %b want 1110", row); else passed++;
        total++; if (num0 !== 4'h0) $display("FAIL mid_num0: got %h want 0", num0); else passed++;
        total++; if (num1 !== 4'h0) $display("FAIL mid_num1: got %h want 0", num1); else passed++;
        total++; if (new_key !== 1'b0) $display("FAIL mid_new_key: got %b want 0", new_key); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (new_key !== 1'b0 || row !== 4'b1110) $display("FAIL mid_hold i=%0d: got new_key=%b row=%b want 0 1110", i, new_key, row); else passed++;
        end
        pressed = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (strobes - s0 !== 1) $display("FAIL mid_count: got %0d want 1", strobes - s0); else passed++;
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_press();
        test_press_bounce();
        test_history();
        test_overlap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
